// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - branch op encoding and request/result bundle for the branch resolve unit
package branch_resolve_pkg;
  localparam int BRANCH_SEL_LENGTH = 3;
  typedef logic [BRANCH_SEL_LENGTH-1:0] branch_sel_t;

  // Encodings follow the RV32I branch funct3 field so decode can pass it straight through.
  localparam branch_sel_t OP_BEQ      = 3'b000;
  localparam branch_sel_t OP_BNE      = 3'b001;
  localparam branch_sel_t OP_BUNKNOWN = 3'b010;
  localparam branch_sel_t OP_BLT      = 3'b100;
  localparam branch_sel_t OP_BGE      = 3'b101;
  localparam branch_sel_t OP_BLTU     = 3'b110;
  localparam branch_sel_t OP_BGEU     = 3'b111;
endpackage

interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  import branch_resolve_pkg::*;

  logic            in_valid;
  logic            in_ready;
  branch_sel_t     in_sel;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pred_target;

  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_next_pc;
  logic            out_mispredict;
  logic            out_illegal;

  modport master (
    output in_valid, in_sel, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, in_pred_target,
    output out_ready,
    input  in_ready,
    input  out_valid, out_taken, out_next_pc, out_mispredict, out_illegal
  );

  modport slave (
    input  in_valid, in_sel, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, in_pred_target,
    input  out_ready,
    output in_ready,
    output out_valid, out_taken, out_next_pc, out_mispredict, out_illegal
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - pipelined branch compare, next-PC and mispredict check with retire counters
module branch_resolve_unit
  import branch_resolve_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_in,
  branch_resolve_unit_if.slave bus,
  output logic [CNT_W-1:0]     branch_count,
  output logic [CNT_W-1:0]     mispredict_count
);

  logic            valid_q [STAGES];
  logic            valid_d [STAGES];
  logic            taken_q [STAGES];
  logic            taken_d [STAGES];
  logic            mis_q   [STAGES];
  logic            mis_d   [STAGES];
  logic            ill_q   [STAGES];
  logic            ill_d   [STAGES];
  logic [XLEN-1:0] npc_q   [STAGES];
  logic [XLEN-1:0] npc_d   [STAGES];

  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic            stall, squash, retire, accept;
  logic            eq, lt_s, lt_u;
  logic            eval_taken, eval_ill, eval_mis;
  logic [XLEN-1:0] eval_npc;

  assign bus.out_valid      = valid_q[STAGES-1];
  assign bus.out_taken      = taken_q[STAGES-1];
  assign bus.out_next_pc    = npc_q[STAGES-1];
  assign bus.out_mispredict = mis_q[STAGES-1];
  assign bus.out_illegal    = ill_q[STAGES-1];
  assign branch_count       = bcnt_q;
  assign mispredict_count   = mcnt_q;

  assign stall        = bus.out_valid && !bus.out_ready;
  assign squash       = bus.out_valid && bus.out_ready && bus.out_mispredict && !flush_in;
  assign retire       = bus.out_valid && bus.out_ready && !flush_in;
  assign bus.in_ready = !stall && !flush_in && !squash;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    eq         = (bus.in_rs1 == bus.in_rs2);
    lt_s       = ($signed(bus.in_rs1) < $signed(bus.in_rs2));
    lt_u       = (bus.in_rs1 < bus.in_rs2);
    eval_taken = 1'b0;
    eval_ill   = 1'b0;
    case (bus.in_sel)
      OP_BEQ:  eval_taken = eq;
      OP_BNE:  eval_taken = !eq;
      OP_BLT:  eval_taken = lt_s;
      OP_BGE:  eval_taken = !lt_s;
      OP_BLTU: eval_taken = lt_u;
      OP_BGEU: eval_taken = !lt_u;
      default: eval_ill   = 1'b1;
    endcase
    eval_npc = eval_taken ? (bus.in_pc + bus.in_imm) : (bus.in_pc + XLEN'(4));
    eval_mis = !eval_ill &&
               ((eval_taken != bus.in_pred_taken) || (eval_npc != bus.in_pred_target));
  end

  // A squash leaves nothing valid: younger stages are killed and the front stage
  // cannot accept because in_ready is low that cycle.
  always_comb begin
    valid_d = valid_q;
    taken_d = taken_q;
    mis_d   = mis_q;
    ill_d   = ill_q;
    npc_d   = npc_q;
    if (flush_in) begin
      for (int i = 0; i < STAGES; i++) valid_d[i] = 1'b0;
    end else if (!stall) begin
      valid_d[0] = accept;
      if (accept) begin
        taken_d[0] = eval_taken;
        mis_d[0]   = eval_mis;
        ill_d[0]   = eval_ill;
        npc_d[0]   = eval_npc;
      end
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1] && !squash;
        if (valid_q[i-1]) begin
          taken_d[i] = taken_q[i-1];
          mis_d[i]   = mis_q[i-1];
          ill_d[i]   = ill_q[i-1];
          npc_d[i]   = npc_q[i-1];
        end
      end
    end
  end

  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (retire && (bcnt_q != '1)) bcnt_d = bcnt_q + CNT_W'(1);
    if (retire && bus.out_mispredict && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_q[i] <= 1'b0;
        taken_q[i] <= 1'b0;
        mis_q[i]   <= 1'b0;
        ill_q[i]   <= 1'b0;
        npc_q[i]   <= '0;
      end
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      taken_q <= taken_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
      npc_q   <= npc_d;
      bcnt_q  <= bcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed bench for branch_resolve_unit at STAGES 1, 2 and 3
module tb_branch_resolve_unit;
  import branch_resolve_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush_a, flush_b, flush_c;
  logic [3:0]  bc_a, mc_a;
  logic [31:0] bc_b, mc_b, bc_c, mc_c;

  int n_checks = 0;
  int n_pass   = 0;

  branch_resolve_unit_if #(.XLEN(32)) ia ();
  branch_resolve_unit_if #(.XLEN(32)) ib ();
  branch_resolve_unit_if #(.XLEN(32)) ic ();

  branch_resolve_unit #(.XLEN(32), .STAGES(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .flush_in(flush_a), .bus(ia),
    .branch_count(bc_a), .mispredict_count(mc_a)
  );
  branch_resolve_unit #(.XLEN(32), .STAGES(3), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .flush_in(flush_b), .bus(ib),
    .branch_count(bc_b), .mispredict_count(mc_b)
  );
  branch_resolve_unit #(.XLEN(32), .STAGES(2), .CNT_W(32)) dut_c (
    .clk(clk), .rst(rst), .flush_in(flush_c), .bus(ic),
    .branch_count(bc_c), .mispredict_count(mc_c)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input branch_sel_t sel, input logic [31:0] rs1, rs2, pc, imm,
                        input logic pt, input logic [31:0] tgt);
    ia.in_sel = sel; ia.in_rs1 = rs1; ia.in_rs2 = rs2; ia.in_pc = pc; ia.in_imm = imm;
    ia.in_pred_taken = pt; ia.in_pred_target = tgt;
  endtask

  task automatic load_b(input branch_sel_t sel, input logic [31:0] rs1, rs2, pc, imm,
                        input logic pt, input logic [31:0] tgt);
    ib.in_sel = sel; ib.in_rs1 = rs1; ib.in_rs2 = rs2; ib.in_pc = pc; ib.in_imm = imm;
    ib.in_pred_taken = pt; ib.in_pred_target = tgt;
  endtask

  task automatic load_c(input branch_sel_t sel, input logic [31:0] rs1, rs2, pc, imm,
                        input logic pt, input logic [31:0] tgt);
    ic.in_sel = sel; ic.in_rs1 = rs1; ic.in_rs2 = rs2; ic.in_pc = pc; ic.in_imm = imm;
    ic.in_pred_taken = pt; ic.in_pred_target = tgt;
  endtask

  // Send one request on dut_a (STAGES=1); result is visible right after the accept edge.
  task automatic send_a(input branch_sel_t sel, input logic [31:0] rs1, rs2, pc, imm,
                        input logic pt, input logic [31:0] tgt);
    load_a(sel, rs1, rs2, pc, imm, pt, tgt);
    ia.in_valid = 1'b1;
    tick();
    ia.in_valid = 1'b0;
  endtask

  branch_sel_t sw_sel   [6] = '{OP_BLT, OP_BLTU, OP_BGE, OP_BGEU, OP_BEQ, OP_BNE};
  logic [31:0] sw_rs1   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] sw_rs2   [6] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000,
                                32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
  logic        sw_taken [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
    ia.in_valid = 1'b0; ia.out_ready = 1'b1; load_a(OP_BEQ, 0, 0, 0, 0, 1'b0, 0);
    ib.in_valid = 1'b0; ib.out_ready = 1'b1; load_b(OP_BEQ, 0, 0, 0, 0, 1'b0, 0);
    ic.in_valid = 1'b0; ic.out_ready = 1'b1; load_c(OP_BEQ, 0, 0, 0, 0, 1'b0, 0);
    repeat (2) tick();
    rst = 1'b0;
    #1;

    check_eq("rst_out_valid", ia.out_valid, 0);
    check_eq("rst_out_taken", ia.out_taken, 0);
    check_eq("rst_out_next_pc", ia.out_next_pc, 0);
    check_eq("rst_out_mispredict", ia.out_mispredict, 0);
    check_eq("rst_out_illegal", ia.out_illegal, 0);
    check_eq("rst_branch_count", bc_a, 0);
    check_eq("rst_mispredict_count", mc_a, 0);
    check_eq("rst_in_ready", ia.in_ready, 1);

    // Compare sweep: prediction is always not-taken to pc+4, so mispredict == taken.
    for (int i = 0; i < 6; i++) begin
      send_a(sw_sel[i], sw_rs1[i], sw_rs2[i], 32'h100, 32'h20, 1'b0, 32'h104);
      check_eq($sformatf("sweep%0d_valid", i), ia.out_valid, 1);
      check_eq($sformatf("sweep%0d_taken", i), ia.out_taken, sw_taken[i]);
      check_eq($sformatf("sweep%0d_next_pc", i), ia.out_next_pc,
               sw_taken[i] ? 32'h120 : 32'h104);
      check_eq($sformatf("sweep%0d_mispredict", i), ia.out_mispredict, sw_taken[i]);
      tick();
    end
    check_eq("sweep_branch_count", bc_a, 6);
    check_eq("sweep_mispredict_count", mc_a, 4);

    send_a(OP_BEQ, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'd8, 1'b1, 32'h0000_0004);
    check_eq("wrap_taken_next_pc", ia.out_next_pc, 32'h0000_0004);
    check_eq("wrap_taken_mispredict", ia.out_mispredict, 0);
    tick();
    send_a(OP_BNE, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'd8, 1'b0, 32'h0000_0000);
    check_eq("wrap_nt_taken", ia.out_taken, 0);
    check_eq("wrap_nt_next_pc", ia.out_next_pc, 32'h0000_0000);
    tick();

    send_a(OP_BUNKNOWN, 32'd1, 32'd1, 32'h200, 32'h40, 1'b1, 32'h999);
    check_eq("ill_taken", ia.out_taken, 0);
    check_eq("ill_illegal", ia.out_illegal, 1);
    check_eq("ill_mispredict", ia.out_mispredict, 0);
    check_eq("ill_next_pc", ia.out_next_pc, 32'h204);
    tick();
    send_a(3'b011, 32'd1, 32'd2, 32'h300, 32'h40, 1'b0, 32'h304);
    check_eq("ill2_illegal", ia.out_illegal, 1);
    check_eq("ill2_next_pc", ia.out_next_pc, 32'h304);
    tick();
    check_eq("ill_branch_count", bc_a, 10);
    check_eq("ill_mispredict_count", mc_a, 4);

    send_a(OP_BEQ, 32'd1, 32'd1, 32'h0, 32'h8, 1'b1, 32'h8);
    check_eq("flush_pre_valid", ia.out_valid, 1);
    flush_a = 1'b1;
    #1;
    check_eq("flush_in_ready", ia.in_ready, 0);
    tick();
    flush_a = 1'b0;
    check_eq("flush_out_valid", ia.out_valid, 0);
    check_eq("flush_branch_count", bc_a, 10);
    check_eq("flush_mispredict_count", mc_a, 4);

    // Saturation: 20 correctly predicted back-to-back retires on a 4-bit counter.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("sat_rst_branch_count", bc_a, 0);
    load_a(OP_BEQ, 32'd1, 32'd1, 32'h0, 32'h10, 1'b1, 32'h10);
    ia.in_valid = 1'b1;
    repeat (20) tick();
    ia.in_valid = 1'b0;
    tick();
    check_eq("sat_branch_count", bc_a, 15);
    check_eq("sat_mispredict_count", mc_a, 0);
    send_a(OP_BEQ, 32'd1, 32'd1, 32'h0, 32'h10, 1'b0, 32'h4);
    tick();
    check_eq("sat_hold_branch_count", bc_a, 15);
    check_eq("sat_one_mispredict", mc_a, 1);

    load_a(OP_BEQ, 32'd1, 32'd1, 32'h0, 32'h10, 1'b1, 32'h10);
    ia.in_valid = 1'b1;
    tick();
    check_eq("midrst_pre_valid", ia.out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ia.in_valid = 1'b0;
    #1;
    check_eq("midrst_out_valid", ia.out_valid, 0);
    check_eq("midrst_branch_count", bc_a, 0);
    check_eq("midrst_mispredict_count", mc_a, 0);
    check_eq("midrst_in_ready", ia.in_ready, 1);

    // Squash on dut_b (STAGES=3): first branch mispredicts, the two behind it die.
    load_b(OP_BEQ, 32'd1, 32'd1, 32'h100, 32'h40, 1'b0, 32'h104);
    ib.in_valid = 1'b1;
    tick();
    check_eq("sq_accept1_ready", ib.in_ready, 1);
    load_b(OP_BNE, 32'd1, 32'd2, 32'h200, 32'h8, 1'b1, 32'h208);
    tick();
    load_b(OP_BLT, 32'd1, 32'd2, 32'h300, 32'h8, 1'b1, 32'h308);
    tick();
    ib.in_valid = 1'b0;
    #1;
    check_eq("sq_out_valid", ib.out_valid, 1);
    check_eq("sq_mispredict", ib.out_mispredict, 1);
    check_eq("sq_next_pc", ib.out_next_pc, 32'h140);
    check_eq("sq_in_ready", ib.in_ready, 0);
    tick();
    check_eq("sq_branch_count", bc_b, 1);
    check_eq("sq_mispredict_count", mc_b, 1);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("sq_killed_c%0d", i), ib.out_valid, 0);
      tick();
    end
    check_eq("sq_final_branch_count", bc_b, 1);

    // Backpressure on dut_c (STAGES=2): two entries held for five cycles, then drain.
    ic.out_ready = 1'b0;
    load_c(OP_BLTU, 32'd1, 32'd2, 32'h1000, 32'h10, 1'b1, 32'h1010);
    ic.in_valid = 1'b1;
    tick();
    load_c(OP_BGEU, 32'd1, 32'd2, 32'h1000, 32'h10, 1'b0, 32'h1004);
    tick();
    ic.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("bp_c%0d_valid", i), ic.out_valid, 1);
      check_eq($sformatf("bp_c%0d_taken", i), ic.out_taken, 1);
      check_eq($sformatf("bp_c%0d_next_pc", i), ic.out_next_pc, 32'h1010);
      check_eq($sformatf("bp_c%0d_in_ready", i), ic.in_ready, 0);
      tick();
    end
    check_eq("bp_hold_branch_count", bc_c, 0);
    ic.out_ready = 1'b1;
    #1;
    check_eq("bp_release_in_ready", ic.in_ready, 1);
    tick();
    check_eq("bp_second_valid", ic.out_valid, 1);
    check_eq("bp_second_taken", ic.out_taken, 0);
    check_eq("bp_second_next_pc", ic.out_next_pc, 32'h1004);
    check_eq("bp_first_retired", bc_c, 1);
    tick();
    check_eq("bp_drained_valid", ic.out_valid, 0);
    check_eq("bp_branch_count", bc_c, 2);
    check_eq("bp_mispredict_count", mc_c, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
